// File: rtl/alert_pkg.sv
// Shared types and helpers for the alert bank:
// per-channel state encoding and channel-index width.
package alert_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMING = 2'd1,
        ST_ALERT  = 2'd2
    } ch_state_e;

    localparam int HOLD_W = 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alert_channel_module.sv
// One alert channel: debounce of the trigger over HOLD_CYCLES
// consecutive cycles, latch until acknowledged with a&b low.
module alert_channel_module
    import alert_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic mask,
    input  logic ack,
    output logic alert,
    output logic enter
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    ch_state_e         state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              both;
    logic              trig;

    assign both  = a & b;
    assign trig  = both & ~mask;
    assign alert = (state_q == ST_ALERT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // hold_q counts trigger cycles already seen in the current run
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        enter   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_ARMING: begin
                if (trig) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_ALERT;
                        hold_d  = '0;
                        enter   = 1'b1;
                    end else begin
                        state_d = ST_ARMING;
                        hold_d  = hold_q + 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end
            end
            ST_ALERT: begin
                if (ack && !both) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase
    end

endmodule

// File: rtl/alert_bank_module.sv
// Bank of independent alert channels with lowest-index
// priority encoder and a saturating alert-entry counter.
module alert_bank_module
    import alert_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int HOLD_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_CH-1:0]              a,
    input  logic [N_CH-1:0]              b,
    input  logic [N_CH-1:0]              mask,
    input  logic [N_CH-1:0]              ack,
    output logic [N_CH-1:0]              alert,
    output logic                         alert_any,
    output logic [idx_w(N_CH)-1:0]       first_id,
    output logic                         first_valid,
    output logic [CNT_W-1:0]             event_cnt
);

    localparam int ID_W  = idx_w(N_CH);
    localparam int SUM_W = 6;
    localparam int EXT_W = CNT_W + SUM_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [N_CH-1:0]  enter;
    logic [SUM_W-1:0] n_enter;
    logic [EXT_W-1:0] cnt_sum;
    logic [CNT_W-1:0] cnt_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        alert_channel_module #(
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .a     (a[i]),
            .b     (b[i]),
            .mask  (mask[i]),
            .ack   (ack[i]),
            .alert (alert[i]),
            .enter (enter[i])
        );
    end

    assign alert_any   = |alert;
    assign first_valid = alert_any;

    // Scan high to low so the lowest set index wins
    always_comb begin
        first_id = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (alert[i]) begin
                first_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        n_enter = '0;
        for (int i = 0; i < N_CH; i++) begin
            n_enter = n_enter + SUM_W'(enter[i]);
        end
        cnt_sum = EXT_W'(event_cnt) + EXT_W'(n_enter);
        if (cnt_sum > EXT_W'(CNT_MAX)) begin
            cnt_d = CNT_MAX;
        end else begin
            cnt_d = cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            event_cnt <= '0;
        end else begin
            event_cnt <= cnt_d;
        end
    end

endmodule
